// File: rtl/chime_buzzer_pkg.sv
// Shared types and default constants for the chime speaker path.
package chime_pkg;

  // Default half-period word width and minimum half-period in clocks.
  localparam int CHIME_WIDTH    = 20;
  localparam int CHIME_MIN_HALF = 2;

  // Width of the saturating strike counter.
  localparam int STRIKE_W = 8;

  // Tone generator state.
  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } chime_state_e;

endpackage

// File: rtl/chime_buzzer_tone_divider.sv
// Loadable half-period counter. Emits a one-cycle boundary pulse on the last
// cycle of each phase while enabled. A load restarts the phase at count 0 with
// a new half-period; while disabled the count is parked at 0.
module tone_divider
  import chime_pkg::*;
#(
  parameter int WIDTH = CHIME_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] half_i,
  output logic             boundary_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] half_q;
  logic [WIDTH-1:0] half_d;
  logic             boundary_s;

  // Last cycle of the current phase; half is always >= 2 while enabled.
  assign boundary_s = en_i && (cnt_q == (half_q - WIDTH'(1)));
  assign boundary_o = boundary_s;

  // Next count and half-period: load wins, otherwise count and wrap.
  always_comb begin
    cnt_d  = cnt_q;
    half_d = half_q;
    if (load_i) begin
      half_d = half_i;
      cnt_d  = '0;
    end else if (en_i) begin
      if (boundary_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Counter and latched half-period registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      half_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
    end
  end

endmodule

// File: rtl/chime_buzzer.sv
// Speaker driver: turns a tone request (enable + half-period word) into a
// glitch-free square wave and counts silence-to-tone strikes.
module chime_buzzer
  import chime_pkg::*;
#(
  parameter int WIDTH    = CHIME_WIDTH,
  parameter int MIN_HALF = CHIME_MIN_HALF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                on,
  input  logic [WIDTH-1:0]    sound,
  input  logic                clr_cnt,
  output logic                speak,
  output logic                busy,
  output logic [STRIKE_W-1:0] strike_cnt
);

  localparam logic [STRIKE_W-1:0] STRIKE_MAX = {STRIKE_W{1'b1}};

  chime_state_e        state_q;
  chime_state_e        state_d;
  logic                speak_q;
  logic                speak_d;
  logic [STRIKE_W-1:0] strike_q;
  logic [STRIKE_W-1:0] strike_d;
  logic                req_s;
  logic                start_s;
  logic                load_s;
  logic                boundary_s;
  logic [WIDTH-1:0]    half_s;

  // Raise short non-zero requests to the minimum half-period (unsigned compare).
  function automatic logic [WIDTH-1:0] clamp_half(input logic [WIDTH-1:0] s);
    if (s < WIDTH'(MIN_HALF)) begin
      return WIDTH'(MIN_HALF);
    end else begin
      return s;
    end
  endfunction

  assign req_s   = on && (sound != '0);
  assign half_s  = clamp_half(sound);
  assign start_s = (state_q == IDLE) && req_s;

  tone_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .en_i      (state_q == RUN),
    .load_i    (load_s),
    .half_i    (half_s),
    .boundary_o(boundary_s)
  );

  // FSM next state: start a tone, and only act on requests at phase boundaries.
  always_comb begin
    state_d = state_q;
    speak_d = speak_q;
    load_s  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          state_d = RUN;
          speak_d = 1'b1;
          load_s  = 1'b1;
        end else begin
          speak_d = 1'b0;
        end
      end
      RUN: begin
        if (boundary_s) begin
          if (req_s) begin
            speak_d = ~speak_q;
            load_s  = 1'b1;
          end else begin
            state_d = IDLE;
            speak_d = 1'b0;
          end
        end else begin
          speak_d = speak_q;
        end
      end
      default: begin
        state_d = IDLE;
        speak_d = 1'b0;
      end
    endcase
  end

  // Strike counter next value: clear first, then count, saturating at max.
  always_comb begin
    strike_d = strike_q;
    if (clr_cnt) begin
      strike_d = start_s ? STRIKE_W'(1) : '0;
    end else if (start_s && (strike_q != STRIKE_MAX)) begin
      strike_d = strike_q + STRIKE_W'(1);
    end else begin
      strike_d = strike_q;
    end
  end

  // State, speaker and strike registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      speak_q  <= 1'b0;
      strike_q <= '0;
    end else begin
      state_q  <= state_d;
      speak_q  <= speak_d;
      strike_q <= strike_d;
    end
  end

  assign speak      = speak_q;
  assign busy       = (state_q == RUN);
  assign strike_cnt = strike_q;

endmodule
